// File: rtl/lut_config_loader_if.sv
// lut_config_loader_if: handshake and LUT configuration bus between a
// configuration source / LUT instance (master side) and the loader (slave side).
interface lut_config_loader_if;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_word;
    logic [3:0]  o_addr;
    logic        o_data;
    logic        o_config_enable;
    logic [3:0]  o_lut_sel;
    logic        i_lut_out;
    logic        o_busy;
    logic        o_done;
    logic        o_verify_err;

    // Source + LUT side: offers words, returns the LUT lookup output.
    modport master (
        output i_valid, i_word, i_lut_out,
        input  o_ready, o_addr, o_data, o_config_enable, o_lut_sel,
               o_busy, o_done, o_verify_err
    );

    // Loader side.
    modport slave (
        input  i_valid, i_word, i_lut_out,
        output o_ready, o_addr, o_data, o_config_enable, o_lut_sel,
               o_busy, o_done, o_verify_err
    );
endinterface

// File: rtl/lut_config_loader.sv
// lut_config_loader: programs a 16-entry truth table into a 4-input LUT one
// entry at a time. Address/data are set up one cycle before config-enable
// rises and held until it falls, so the level-sensitive LUT storage never
// sees a transient.
// Optional feature macro: LUT_VERIFY_EN builds a readback pass that checks
// every entry through the LUT lookup path and raises a sticky error flag.
module lut_config_loader #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    lut_config_loader_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    // Elaboration-time guard on the enable pulse width.
    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
            $error("lut_config_loader: HOLD_CYCLES=%0d is outside 1..15", HOLD_CYCLES);
        end
    endgenerate

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] word_q, word_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cfg_en_q, cfg_en_d;
    logic [3:0]  addr_q, addr_d;
    logic        data_q, data_d;
`ifdef LUT_VERIFY_EN
    logic        phase_q, phase_d;
    logic        verr_q, verr_d;
    logic [3:0]  lut_sel_q, lut_sel_d;
`endif

    // Next-state logic plus output decode from the next state so every
    // output is a flop aligned with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        word_d     = word_q;
`ifdef LUT_VERIFY_EN
        phase_d    = phase_q;
        verr_d     = verr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && ready_q) begin
                    word_d  = bus.i_word;
                    idx_d   = 4'd0;
                    state_d = ST_SETUP;
`ifdef LUT_VERIFY_EN
                    verr_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                hold_cnt_d = 4'd0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = 4'd0;
                    if (idx_q != 4'd15) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SETUP;
                    end else begin
                        idx_d   = 4'd0;
`ifdef LUT_VERIFY_EN
                        phase_d = 1'b0;
                        state_d = ST_VERIFY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
`ifdef LUT_VERIFY_EN
            ST_VERIFY: begin
                if (!phase_q) begin
                    // First cycle: lookup index is already on o_lut_sel.
                    phase_d = 1'b1;
                end else begin
                    // Second cycle: LUT output has settled, compare it.
                    phase_d = 1'b0;
                    if (bus.i_lut_out != word_q[idx_q]) begin
                        verr_d = 1'b1;
                    end else begin
                        verr_d = verr_q;
                    end
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        cfg_en_d = (state_d == ST_HOLD);

        // Address/data move only on entry to SETUP, where enable is low.
        if (state_d == ST_SETUP) begin
            addr_d = idx_d;
            data_d = word_d[idx_d];
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end

`ifdef LUT_VERIFY_EN
        if (state_d == ST_VERIFY) begin
            lut_sel_d = idx_d;
        end else begin
            lut_sel_d = lut_sel_q;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            hold_cnt_q <= 4'd0;
            word_q     <= 16'h0000;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_en_q   <= 1'b0;
            addr_q     <= 4'd0;
            data_q     <= 1'b0;
`ifdef LUT_VERIFY_EN
            phase_q    <= 1'b0;
            verr_q     <= 1'b0;
            lut_sel_q  <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_en_q   <= cfg_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef LUT_VERIFY_EN
            phase_q    <= phase_d;
            verr_q     <= verr_d;
            lut_sel_q  <= lut_sel_d;
`endif
        end
    end

    assign bus.o_ready         = ready_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
    assign bus.o_config_enable = cfg_en_q;
    assign bus.o_addr          = addr_q;
    assign bus.o_data          = data_q;
`ifdef LUT_VERIFY_EN
    assign bus.o_lut_sel       = lut_sel_q;
    assign bus.o_verify_err    = verr_q;
`else
    assign bus.o_lut_sel       = 4'd0;
    assign bus.o_verify_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed bench for lut_config_loader with a LUT model
// per instance (HOLD_CYCLES=2 main instance, HOLD_CYCLES=1 second instance).
`timescale 1ns/1ps
module tb_lut_config_loader;

`ifdef LUT_VERIFY_EN
    localparam int VCYC = 32;
`else
    localparam int VCYC = 0;
`endif
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_config_loader_if bus();
    lut_config_loader_if bus1();

    lut_config_loader #(.HOLD_CYCLES(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    lut_config_loader #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int tests_run    = 0;
    int tests_failed = 0;

    // LUT models: storage written while enable is high, optional stuck-at-0 on entry 7.
    logic [15:0] lut_mem  = 16'h0000;
    logic [15:0] lut_mem1 = 16'h0000;
    logic        stuck7   = 1'b0;

    always @(posedge clk) begin
        if (bus.o_config_enable === 1'b1)
            lut_mem[bus.o_addr] <= bus.o_data & ~(stuck7 && bus.o_addr == 4'd7);
        if (bus1.o_config_enable === 1'b1)
            lut_mem1[bus1.o_addr] <= bus1.o_data;
    end
    assign bus.i_lut_out  = lut_mem[bus.o_lut_sel];
    assign bus1.i_lut_out = lut_mem1[bus1.o_lut_sel];

    // Write-protocol monitor on the main instance.
    logic [3:0] p_addr;
    logic       p_data;
    logic       p_en;
    int         run_len    = 0;
    int         proto_errs = 0;
    int         runs       = 0;
    int         done_cnt   = 0;
    int         tie_errs   = 0;
    logic       mon_on     = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            p_en    <= 1'b0;
            p_addr  <= 4'd0;
            p_data  <= 1'b0;
            run_len <= 0;
        end else begin
            if (bus.o_config_enable) begin
                if (bus.o_addr != p_addr || bus.o_data != p_data) proto_errs <= proto_errs + 1;
                run_len <= run_len + 1;
            end else begin
                if (p_en) begin
                    if (run_len != HOLD) proto_errs <= proto_errs + 1;
                    runs <= runs + 1;
                end
                run_len <= 0;
            end
            p_en   <= bus.o_config_enable;
            p_addr <= bus.o_addr;
            p_data <= bus.o_data;
        end
        if (bus.o_done === 1'b1) done_cnt <= done_cnt + 1;
`ifndef LUT_VERIFY_EN
        if (mon_on && !rst && (bus.o_lut_sel !== 4'd0 || bus1.o_lut_sel !== 4'd0 ||
                               bus.o_verify_err !== 1'b0 || bus1.o_verify_err !== 1'b0))
            tie_errs <= tie_errs + 1;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for o_ready, present the word for the accept cycle T, return in cycle T+1.
    task automatic start_word(input logic [15:0] w, output int waited);
        waited = 0;
        while (bus.o_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        bus.i_valid = 1'b1;
        bus.i_word  = w;
        tick();
        bus.i_valid = 1'b0;
        bus.i_word  = 16'h0000;
    endtask

    // Called in cycle T+k0; returns k such that o_done is high in cycle T+k.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (bus.o_done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_word   = 16'hFFFF;
        bus1.i_valid = 1'b0;
        bus1.i_word  = 16'h0000;
        repeat (3) tick();
        tests_run++;
        if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
            bus.o_config_enable !== 1'b0 || bus.o_addr !== 4'd0 || bus.o_data !== 1'b0 ||
            bus.o_lut_sel !== 4'd0 || bus.o_verify_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b en=%b addr=%0d data=%b sel=%0d err=%b, expected all 0",
                     bus.o_ready, bus.o_busy, bus.o_done, bus.o_config_enable, bus.o_addr,
                     bus.o_data, bus.o_lut_sel, bus.o_verify_err);
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", bus.o_ready, bus.o_busy);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_program();
        int w;
        int k;
        int runs0;
        logic [15:0] exp_w;
        exp_w = 16'hA5C3;
        runs0 = runs;
        start_word(exp_w, w);
        tests_run++;
        if (bus.o_addr !== 4'd0 || bus.o_data !== 1'b1 || bus.o_config_enable !== 1'b0 || bus.o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL setup0: got addr=%0d data=%b en=%b busy=%b, expected addr=0 data=1 en=0 busy=1",
                     bus.o_addr, bus.o_data, bus.o_config_enable, bus.o_busy);
        end
        tick();
        tests_run++;
        if (bus.o_config_enable !== 1'b1 || bus.o_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL hold0: got en=%b addr=%0d, expected en=1 addr=0", bus.o_config_enable, bus.o_addr);
        end
        wait_done(2, k);
        tests_run++;
        if (k != 1 + 16 * (1 + HOLD) + VCYC) begin
            tests_failed++;
            $display("FAIL done_latency: got T+%0d expected T+%0d", k, 1 + 16 * (1 + HOLD) + VCYC);
        end
        tests_run++;
        if (bus.o_verify_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL verify_clean: got %b expected 0", bus.o_verify_err);
        end
        tick();
        tests_run++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_done: got rdy=%b busy=%b done=%b expected 1 0 0", bus.o_ready, bus.o_busy, bus.o_done);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (lut_mem[i] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL lut_entry_%0d: got %b expected %b", i, lut_mem[i], exp_w[i]);
            end
        end
        tests_run++;
        if (runs - runs0 != 16 || proto_errs != 0) begin
            tests_failed++;
            $display("FAIL write_protocol: got %0d enable pulses, %0d violations; expected 16, 0", runs - runs0, proto_errs);
        end
    endtask

    task automatic test_busy_ignore();
        int w;
        int k;
        start_word(16'h5A3C, w);
        repeat (5) tick();
        tests_run++;
        if (bus.o_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ready: got %b expected 0", bus.o_ready);
        end
        bus.i_valid = 1'b1;
        bus.i_word  = 16'h1234;
        tick();
        bus.i_valid = 1'b0;
        bus.i_word  = 16'h0000;
        wait_done(7, k);
        tests_run++;
        if (k != 1 + 16 * (1 + HOLD) + VCYC) begin
            tests_failed++;
            $display("FAIL busy_latency: got T+%0d expected T+%0d", k, 1 + 16 * (1 + HOLD) + VCYC);
        end
        tick();
        tick();
        tests_run++;
        if (lut_mem !== 16'h5A3C || bus.o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignored: got lut=%h busy=%b expected lut=5a3c busy=0", lut_mem, bus.o_busy);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int k;
        start_word(16'h0F0F, w);
        wait_done(1, k);
        tick();
        start_word(16'hF0F0, w);
        tests_run++;
        if (w != 0) begin
            tests_failed++;
            $display("FAIL b2b_ready: waited %0d cycles expected 0", w);
        end
        wait_done(1, k);
        tests_run++;
        if (k != 1 + 16 * (1 + HOLD) + VCYC) begin
            tests_failed++;
            $display("FAIL b2b_latency: got T+%0d expected T+%0d", k, 1 + 16 * (1 + HOLD) + VCYC);
        end
        tick();
        tests_run++;
        if (lut_mem !== 16'hF0F0) begin
            tests_failed++;
            $display("FAIL b2b_contents: got %h expected f0f0", lut_mem);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int d0;
        start_word(16'hFFFF, w);
        repeat (27) tick();
        tests_run++;
        if (bus.o_addr !== 4'd9 || bus.o_config_enable !== 1'b0 || bus.o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL setup9: got addr=%0d en=%b busy=%b expected addr=9 en=0 busy=1",
                     bus.o_addr, bus.o_config_enable, bus.o_busy);
        end
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        tests_run++;
        if (bus.o_config_enable !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b0 ||
            bus.o_addr !== 4'd0 || bus.o_data !== 1'b0 || bus.o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got en=%b busy=%b rdy=%b addr=%0d data=%b done=%b expected all 0",
                     bus.o_config_enable, bus.o_busy, bus.o_ready, bus.o_addr, bus.o_data, bus.o_done);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_ready: got %b expected 1", bus.o_ready);
        end
        repeat (5) tick();
        tests_run++;
        if (done_cnt != d0 || lut_mem !== 16'hF1FF) begin
            tests_failed++;
            $display("FAIL mid_reset_abort: got done pulses=%0d lut=%h expected 0 f1ff", done_cnt - d0, lut_mem);
        end
    endtask

`ifdef LUT_VERIFY_EN
    task automatic test_verify_err();
        int w;
        int k;
        stuck7 = 1'b1;
        start_word(16'hFFFF, w);
        repeat (63) tick();
        tests_run++;
        if (bus.o_verify_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL verr_before7: got %b expected 0", bus.o_verify_err);
        end
        tick();
        tests_run++;
        if (bus.o_verify_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL verr_after7: got %b expected 1", bus.o_verify_err);
        end
        wait_done(65, k);
        tests_run++;
        if (k != 81 || bus.o_verify_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL verr_done: got T+%0d err=%b expected T+81 err=1", k, bus.o_verify_err);
        end
        stuck7 = 1'b0;
        tick();
        start_word(16'hA5C3, w);
        tests_run++;
        if (bus.o_verify_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL verr_clear: got %b expected 0", bus.o_verify_err);
        end
        wait_done(1, k);
        tick();
    endtask
`endif

    task automatic test_hold1();
        int k;
        k = 0;
        while (bus1.o_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        bus1.i_valid = 1'b1;
        bus1.i_word  = 16'h0001;
        tick();
        bus1.i_valid = 1'b0;
        bus1.i_word  = 16'h0000;
        k = 1;
        while (bus1.o_done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        tests_run++;
        if (k != 1 + 16 * 2 + VCYC) begin
            tests_failed++;
            $display("FAIL hold1_latency: got T+%0d expected T+%0d", k, 1 + 16 * 2 + VCYC);
        end
        tick();
        tests_run++;
        if (lut_mem1 !== 16'h0001) begin
            tests_failed++;
            $display("FAIL hold1_contents: got %h expected 0001", lut_mem1);
        end
    endtask

    task automatic test_tied_outputs();
`ifndef LUT_VERIFY_EN
        tests_run++;
        if (tie_errs != 0) begin
            tests_failed++;
            $display("FAIL tied_outputs: got %0d cycles with lut_sel/verify_err nonzero expected 0", tie_errs);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_program();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef LUT_VERIFY_EN
        test_verify_err();
`endif
        test_hold1();
        test_tied_outputs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
